// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game: button count, index width,
// FSM state encoding and small button-vector helpers.
package simon_pkg;

  localparam int NUM_BUTTONS = 4;
  localparam int BTN_IDX_W   = 2;

  // Front-end FSM state encoding, kept as plain constants so legacy code can match on them
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Binary index of the set bit in a one-hot button vector (0 when no bit is set)
  function automatic logic [BTN_IDX_W-1:0] encodeOneHot(input logic [NUM_BUTTONS-1:0] oneHot);
    logic [BTN_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (oneHot[i]) idx = BTN_IDX_W'(i);
    end
    return idx;
  endfunction

  // Number of buttons currently active in a vector
  function automatic int countActive(input logic [NUM_BUTTONS-1:0] btnVec);
    int n;
    n = 0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (btnVec[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/simon_debounce.sv
// One button bit: two-flop synchronizer followed by a counter-based
// debouncer. The debounced state only flips after DEBOUNCE_CYCLES
// consecutive synchronized samples disagree with it.
module simon_debounce #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btnRaw,
  output logic syncOut,
  output logic debOut
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       meta;
  logic       syncQ;
  logic       debQ;
  logic [3:0] stableCnt;

  // Bring the asynchronous raw button into the clk domain
  // NOTE: non-blocking assignments let the two flops shift as a pipeline; blocking would collapse them into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta  <= 1'b0;
      syncQ <= 1'b0;
    end else begin
      meta  <= btnRaw;
      syncQ <= meta;
    end
  end

  // Count consecutive mismatching samples; flip the debounced bit once the run is long enough
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debQ      <= 1'b0;
      stableCnt <= '0;
    end else if (syncQ != debQ) begin
      if (stableCnt == CNT_LAST) begin
        debQ      <= syncQ;
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + 4'd1;
      end
    end else begin
      stableCnt <= '0;
    end
  end

  assign syncOut = syncQ;
  assign debOut  = debQ;

endmodule

// File: rtl/simon_input.sv
// Player-button front end for Simon: synchronizes and debounces four
// buttons, then turns a single clean press into a one-cycle pulse plus a
// held button index. Chords are flagged and rejected, and the block stays
// locked until every button has been quiet for DEBOUNCE_CYCLES+2 edges.
module simon_input
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_BUTTONS-1:0] btn,
  input  logic                  enable,
  output logic [BTN_IDX_W-1:0]  player_num,
  output logic                  player_pressed,
  output logic                  chord_error,
  output logic                  locked
);

  localparam logic [4:0] QUIET_LAST = 5'(DEBOUNCE_CYCLES + 1);

  logic [NUM_BUTTONS-1:0] sync;
  logic [NUM_BUTTONS-1:0] deb;

  logic [0:0]           state;
  logic [4:0]           quietCnt;
  logic                 debSingle;
  logic                 debChord;
  logic [BTN_IDX_W-1:0] debIdx;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    simon_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .btnRaw (btn[i]),
      .syncOut(sync[i]),
      .debOut (deb[i])
    );
  end

  // Classify the debounced vector as a single press or a chord and encode its index
  // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
  always_comb begin
    debSingle = 1'b0;
    debChord  = 1'b0;
    debIdx    = encodeOneHot(deb);
    if (countActive(deb) == 1) debSingle = 1'b1;
    if (countActive(deb) > 1)  debChord  = 1'b1;
  end

  // FSM with quiet counter and registered outputs; pulses default low every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_LOCKED;
      quietCnt       <= '0;
      player_num     <= '0;
      player_pressed <= 1'b0;
      chord_error    <= 1'b0;
    end else begin
      player_pressed <= 1'b0;
      chord_error    <= 1'b0;
      case (state)
        ST_LOCKED: begin
          // Re-arm only after every synchronized button has been low for a full quiet run
          if (sync != '0) begin
            quietCnt <= '0;
          end else if (quietCnt == QUIET_LAST) begin
            quietCnt <= '0;
            state    <= ST_IDLE;
          end else begin
            quietCnt <= quietCnt + 5'd1;
          end
        end
        default: begin
          quietCnt <= '0;
          if (debChord) begin
            chord_error <= 1'b1;
            state       <= ST_LOCKED;
          end else if (debSingle) begin
            // A press seen while disabled still consumes the press and locks
            if (enable) begin
              player_pressed <= 1'b1;
              player_num     <= debIdx;
            end
            state <= ST_LOCKED;
          end
        end
      endcase
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_simon_input.sv
// Bench for simon_input with DEBOUNCE_CYCLES = 3. Stimulus pushes the
// expected pulse (kind, index, cycle) into a scoreboard; a monitor pops
// and compares each pulse the DUT shows. Inputs change on the falling
// edge, so a button raised at cycle c is first seen at edge c+1 and its
// pulse is visible at cycle c+6.
module tb_simon_input;

  localparam int D = 3;

  typedef struct {
    logic [1:0] kind;   // {chord_error, player_pressed}
    logic [1:0] num;
    int         cycle;
  } evt_t;

  localparam logic [1:0] K_PRESS = 2'b01;
  localparam logic [1:0] K_CHORD = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = 4'b0;
  logic       enable = 1'b1;
  logic [1:0] player_num;
  logic       player_pressed;
  logic       chord_error;
  logic       locked;

  int   cycle = 0;
  int   total = 0;
  int   passed = 0;
  int   pressSeen = 0;
  int   chordSeen = 0;
  evt_t sbQ[$];

  simon_input #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .enable        (enable),
    .player_num    (player_num),
    .player_pressed(player_pressed),
    .chord_error   (chord_error),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected pulse for a button change applied at the current falling edge
  task automatic expectEvt(input logic [1:0] kind, input logic [1:0] num);
    evt_t e;
    e.kind  = kind;
    e.num   = num;
    e.cycle = cycle + 6;
    sbQ.push_back(e);
  endtask

  // Release everything and confirm the lock lasts exactly D+2 quiet edges
  task automatic releaseAndRearm(input string name);
    btn = 4'b0;
    tick(6);
    check({name, "_still_locked"}, int'(locked), 1);
    tick(1);
    check({name, "_rearmed"}, int'(locked), 0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && (player_pressed || chord_error)) begin
      if (sbQ.size() == 0) begin
        check("unexpected_pulse", int'({chord_error, player_pressed}), 0);
      end else begin
        evt_t e;
        e = sbQ.pop_front();
        check("pulse_kind", int'({chord_error, player_pressed}), int'(e.kind));
        check("pulse_num", int'(player_num), int'(e.num));
        check("pulse_cycle", cycle, e.cycle);
      end
      pressSeen <= pressSeen + int'(player_pressed);
      chordSeen <= chordSeen + int'(chord_error);
    end
  end

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_num", int'(player_num), 0);
    check("rst_pressed", int'(player_pressed), 0);
    check("rst_chord", int'(chord_error), 0);
    check("rst_locked", int'(locked), 1);
    tick(3);
    reset = 1'b0;
    tick(4);
    check("boot_locked", int'(locked), 1);
    tick(1);
    check("boot_idle", int'(locked), 0);

    // Clean press of button 2
    btn = 4'b0100;
    expectEvt(K_PRESS, 2'd2);
    tick(10);
    check("clean_num", int'(player_num), 2);
    check("clean_locked", int'(locked), 1);
    releaseAndRearm("clean");
    check("clean_count", pressSeen, 1);

    // Bounce on button 1: never long enough to debounce
    btn = 4'b0010; tick(1);
    btn = 4'b0000; tick(1);
    btn = 4'b0010; tick(1);
    btn = 4'b0000; tick(10);
    check("bounce_idle", int'(locked), 0);
    check("bounce_num", int'(player_num), 2);
    check("bounce_count", pressSeen, 1);

    // Chord of buttons 0 and 3
    btn = 4'b1001;
    expectEvt(K_CHORD, 2'd2);
    tick(12);
    check("chord_num", int'(player_num), 2);
    check("chord_locked", int'(locked), 1);
    releaseAndRearm("chord");
    check("chord_count", chordSeen, 1);
    check("chord_press_count", pressSeen, 1);

    // Press while disabled, enable raised during the hold
    enable = 1'b0;
    btn = 4'b1000;
    tick(8);
    check("dis_locked", int'(locked), 1);
    enable = 1'b1;
    tick(4);
    check("dis_count", pressSeen, 1);
    check("dis_num", int'(player_num), 2);
    releaseAndRearm("dis");
    btn = 4'b1000;
    expectEvt(K_PRESS, 2'd3);
    tick(10);
    check("repress_num", int'(player_num), 3);
    releaseAndRearm("repress");

    // Button held through a reset pulse
    btn = 4'b0010;
    tick(3);
    reset = 1'b1;
    #1;
    check("midrst_num", int'(player_num), 0);
    check("midrst_pressed", int'(player_pressed), 0);
    check("midrst_chord", int'(chord_error), 0);
    check("midrst_locked", int'(locked), 1);
    tick(2);
    reset = 1'b0;
    tick(12);
    check("held_locked", int'(locked), 1);
    check("held_count", pressSeen, 2);
    releaseAndRearm("held");
    btn = 4'b0010;
    expectEvt(K_PRESS, 2'd1);
    tick(10);
    releaseAndRearm("after_rst");

    // Back-to-back presses at minimum spacing
    btn = 4'b0001;
    expectEvt(K_PRESS, 2'd0);
    tick(4);
    releaseAndRearm("b2b_first");
    btn = 4'b0100;
    expectEvt(K_PRESS, 2'd2);
    tick(4);
    releaseAndRearm("b2b_second");
    check("b2b_num", int'(player_num), 2);

    tick(4);
    check("total_presses", pressSeen, 5);
    check("total_chords", chordSeen, 1);
    check("scoreboard_drained", sbQ.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simon_input.md
# simon_input

Player-button front end for the Simon game. Converts four raw, asynchronous, bouncing push-buttons into the `player_num` / `player_pressed` pair consumed by the Simon sequencer. It performs synchronization, per-button debouncing, one-hot to binary encoding and single-cycle press pulsing. It also rejects chords, presses while disabled, and buttons held through reset. Runs on the 60 Hz game clock.

## Interface
- `DEBOUNCE_CYCLES`, default 3: consecutive stable samples required to change a debounced button state. Range 1..15.
- `clk` in 1: 60 Hz game clock.
- `reset` in 1: asynchronous, active-high.
- `btn` in 4: raw buttons, active-high, asynchronous. Bit i selects colour i.
- `enable` in 1: presses are accepted only while high. Tie to the inverse of Simon's turn flag.
- `player_num` out 2: index of the last accepted button. Held until the next accepted press.
- `player_pressed` out 1: one-cycle pulse per accepted press.
- `chord_error` out 1: one-cycle pulse when more than one button is debounced-active at press detection.
- `locked` out 1: high while the FSM waits for all buttons to be released.

## Operation
- Synchronizer:
  - 2-FF synchronizer per bit produces the `sync[3:0]` vector.
  - Reset value is 0.
- Debounce, per bit:
  - Keeps a `deb` bit and a 4-bit counter.
  - When `sync != deb`, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the mismatch is still present, `deb` flips and the counter clears.
  - Any cycle with `sync == deb` clears the counter.
  - Reset: `deb` = 0, counter = 0.
- FSM, two states:
  - `LOCKED` (reset state): a 5-bit quiet counter counts consecutive edges with `sync == 0`. Any nonzero `sync` clears it. When the count reaches `DEBOUNCE_CYCLES+2`, go to `IDLE` and clear the counter.
  - `IDLE`, `deb == 0`: stay.
  - `IDLE`, `deb` one-hot and `enable = 1`: pulse `player_pressed`, load `player_num` with the encoded index, go to `LOCKED`.
  - `IDLE`, `deb` one-hot and `enable = 0`: press is ignored, no pulse. Go to `LOCKED`.
  - `IDLE`, `deb` has two or more bits set: pulse `chord_error` regardless of `enable`. No `player_pressed`, `player_num` unchanged. Go to `LOCKED`.
- `locked` = (state == `LOCKED`).
- A button held through reset never produces a press. Its `sync` rises within 2 edges, before the quiet count (≥3) completes.
- `enable` changing while in `LOCKED` has no effect. The operator must release and press again.
- Reset mid-operation:
  - All outputs return to reset values immediately (asynchronous).
  - State goes to `LOCKED`.
  - Debounce and quiet counters clear.

## Timing
- Reset values: `player_num` = 0, `player_pressed` = 0, `chord_error` = 0, `locked` = 1.
- Press latency:
  - Raw bit high before edge t and stable, FSM in `IDLE`: `deb` rises at edge t+1+D and `player_pressed` is high after edge t+2+D, for exactly one cycle.
  - With D = 3: pulse on the cycle following edge t+5.
  - `player_num` updates on the same edge as the pulse.
- Glitch rejection: a raw pulse or bounce shorter than D consecutive synchronized samples changes nothing.
- Release to re-arm: after the last `sync` bit falls, the FSM returns to `IDLE` after D+2 quiet edges.
- Minimum spacing between two accepted presses is therefore about 2D+5 cycles. With D = 3 that is about 183 ms at 60 Hz, well inside Simon's 120-cycle player timeout.
- Outputs are registered. There are no combinational paths from `btn` or `enable` to any output.

## Structure
- Package `simon_pkg`:
  - `NUM_BUTTONS` = 4.
  - `BTN_IDX_W` = 2.
  - FSM state encoding `ST_IDLE`, `ST_LOCKED`.
  - Shared with the Simon sequencer and the display block.
- Sub-module `simon_debounce`: one bit, synchronizer plus debounce counter, parameterized by `DEBOUNCE_CYCLES`. Instantiated 4 times.
- Top level holds the quiet counter, the FSM, the encoder and the output registers.

## Test plan
- Clean press, D = 3: after reset, wait for `locked` = 0. Raise `btn[2]` before edge t and hold 10 cycles. Expect `player_pressed` high for exactly the cycle after edge t+5 and `player_num` = 2. `locked` = 1 until 5 quiet edges after release.
- Bounce: `btn[1]` pattern 1,0,1,0 on consecutive cycles, then low. Expect no `player_pressed`, `deb` never rises, `player_num` unchanged.
- Chord: raise `btn[0]` and `btn[3]` on the same cycle and hold. Expect a single `chord_error` pulse, no `player_pressed`, `player_num` unchanged. No further pulses until both are released for 5 edges.
- Disabled press: `enable` = 0, press `btn[3]`. Raise `enable` while the button is still held. Expect no pulse. After release and re-press with `enable` = 1, expect a pulse with `player_num` = 3.
- Held through reset:
  - Hold `btn[1]`, assert `reset` for 2 cycles mid-hold. Expect all outputs at reset values and no pulse while held.
  - After release plus 5 quiet edges and a new press, expect a pulse with `player_num` = 1.
- Back-to-back presses: press 0, release, press 2 with `enable` = 1 and minimum spacing. Expect two pulses, carrying `player_num` 0 then 2.
